freq_generator: RTL and testbench
=================================

Name: freq_generator

Overview:
- Programmable square-wave and strobe generator.
- It is the transmit-side counterpart of the frequency counter: the counter measures an unknown clock against the reference, and this block synthesises a signal of programmed period from the reference clock.
- Used as a test stimulus source for the counter and as a general-purpose timebase.
- A period word is loaded through a valid/ready handshake and applied glitch-free at the next period boundary.

Parameters:
CNTR_SIZE, 10, width of period word and internal period counter.
PSC_DIV, 1, reference prescaler; the period counter advances once every PSC_DIV clk cycles (must be >= 1).

Ports:
clk  in  1  reference clock; all logic on its rising edge.
rst  in  1  asynchronous, active-low reset.
en  in  1  run enable, level-sensitive.
period_in  in  CNTR_SIZE  requested period, in prescaled ticks.
period_valid  in  1  period_in is valid.
period_ready  out  1  block can accept a period word.
wave_out  out  1  square-wave output, registered.
pulse_out  out  1  one-clk strobe at the start of each period, registered.
running  out  1  high while in RUN state.

Behaviour:
- Reset (rst=0, asynchronous) clears all state immediately:
  - wave_out=0, pulse_out=0, running=0, period_ready=1.
  - Active period reg=0, pending flag=0, prescaler=0, cnt=0, state=IDLE.
  - All registers are cleared with the same asynchronous reset; no synchronous clears.
- Prescaler:
  - A tick is asserted for one clk every PSC_DIV cycles. With PSC_DIV=1, tick is asserted every cycle.
  - The prescaler is held at 0 while in IDLE.
- Clamping: the effective period is Pe = max(period_in, 2). Values 0 and 1 are accepted and stored as 2.
- Handshake:
  - A transfer occurs on a clk edge where period_valid=1 and period_ready=1.
  - On transfer, Pe goes to the pending reg, the pending flag is set, and period_ready drops on the next cycle.
  - period_ready returns high the cycle after the pending value is committed to the active reg.
  - period_valid while ready=0 is ignored; the producer must hold it.
- Commit:
  - In IDLE, pending commits on the cycle after transfer.
  - In RUN, pending commits only at the period boundary: tick with cnt=P-1.
  - The new period takes effect from cnt=0 of the next period. No truncated or stretched periods.
- States:
  - IDLE -> RUN when en=1 and active period != 0. Entry sets cnt=0 and prescaler=0.
  - RUN -> IDLE when en=0. This is abrupt: the next cycle gives wave_out=0, pulse_out=0, cnt=0, running=0. The active period is retained.
  - A pending word survives disable and commits in IDLE.
- Counting in RUN:
  - On each tick, cnt <= (cnt==P-1) ? 0 : cnt+1. Wrap-around is at P-1, never at 2^CNTR_SIZE.
- Outputs (registered, one clk after the state/cnt they reflect):
  - wave_out = 1 while cnt < (P>>1); otherwise 0. Odd P gives low > high by one tick.
  - pulse_out = 1 for exactly one clk on the first clk where cnt=0 of each period, including the RUN entry period.
  - running mirrors the state.
- Latency: en rises with an active period loaded, so RUN is entered on the next edge; wave_out and pulse_out go high one edge later (2 clk from en sampled).
- Simultaneous events:
  - Transfer on the same edge as a boundary: the word becomes pending and commits at the following boundary.
  - en falling on a boundary edge: disable wins and no pulse is emitted.
- Width: cnt and the period regs are CNTR_SIZE bits. Maximum period is 2^CNTR_SIZE-1 ticks.

Test Plan:
- Reset mid-RUN (P=10) -> all outputs 0 asynchronously and period_ready=1 before the next clk edge; after release, running=0 until en is reasserted.
- PSC_DIV=1, load period_in=8, en=1 -> wave_out 4 clk high / 4 low repeating; pulse_out one clk every 8 clk; first pulse 2 clk after en is sampled.
- Load period_in=0 and period_in=1 separately -> each behaves as P=2: wave_out toggles every clk and pulse_out is high every 2nd clk; load period_in=5 -> wave_out 2 high / 3 low.
- Running P=6, transfer period_in=12 at cnt=2 -> current period completes all 6 ticks; next period is 12 (6 high / 6 low); period_ready low from the transfer until the cycle after the boundary.
- PSC_DIV=4, P=3 -> output period is 12 clk, wave_out 4 clk high / 8 low; period_valid while ready=0 leaves the pending value unchanged.
- en dropped at cnt=3 of P=10, then reasserted -> outputs low the cycle after drop; on re-entry, counting restarts at cnt=0 with a fresh pulse_out and the same period 10.

Source files
------------

// File: rtl/freq_generator.sv
`default_nettype none
// ============================================================================
// freq_generator : programmable square-wave / strobe generator. Period words
// arrive by valid/ready and are applied only at a period boundary.
// Revision 1.0
// ============================================================================
module freq_generator #(
  parameter int CNTR_SIZE = 10,
  parameter int PSC_DIV   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [CNTR_SIZE-1:0] period_in,
  input  logic                 period_valid,
  output logic                 period_ready,
  output logic                 wave_out,
  output logic                 pulse_out,
  output logic                 running
);

  localparam int                   PSC_W      = (PSC_DIV > 1) ? $clog2(PSC_DIV) : 1;
  localparam logic [PSC_W-1:0]     PSC_LAST   = PSC_W'(PSC_DIV - 1);
  localparam logic [CNTR_SIZE-1:0] MIN_PERIOD = CNTR_SIZE'(2);
  localparam logic [0:0]           S_IDLE     = 1'b0;
  localparam logic [0:0]           S_RUN      = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [PSC_W-1:0]     psc_q, psc_d;
  logic [CNTR_SIZE-1:0] cnt_q, cnt_d;
  logic [CNTR_SIZE-1:0] active_q, active_d;
  logic [CNTR_SIZE-1:0] pend_val_q, pend_val_d;
  logic                 pend_q, pend_d;
  logic                 wave_q, wave_d;
  logic                 pulse_q, pulse_d;

  logic                 tick;
  logic                 at_end;
  logic                 xfer;
  logic [CNTR_SIZE-1:0] clamped;

  always_comb begin
    state_d    = state_q;
    psc_d      = psc_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    wave_d     = 1'b0;
    pulse_d    = 1'b0;

    clamped = (period_in < MIN_PERIOD) ? MIN_PERIOD : period_in;
    xfer    = period_valid && !pend_q;
    tick    = (psc_q == PSC_LAST);
    at_end  = tick && (cnt_q == (active_q - CNTR_SIZE'(1)));

    case (state_q)
      S_IDLE: begin
        psc_d = '0;
        cnt_d = '0;
        if (pend_q) begin
          active_d = pend_val_q;
          pend_d   = 1'b0;
        end
        // Entry decision uses the period already active, not one committing now.
        if (en && (active_q != '0)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!en) begin
          state_d = S_IDLE;
          psc_d   = '0;
          cnt_d   = '0;
        end else begin
          wave_d  = (cnt_q < (active_q >> 1));
          // psc is zero only on the first clk of each count value.
          pulse_d = (cnt_q == '0) && (psc_q == '0);
          psc_d   = tick ? '0 : psc_q + PSC_W'(1);
          if (tick) begin
            if (at_end) begin
              cnt_d = '0;
              if (pend_q) begin
                active_d = pend_val_q;
                pend_d   = 1'b0;
              end
            end else begin
              cnt_d = cnt_q + CNTR_SIZE'(1);
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A transfer needs an empty pending slot, so it never collides with a commit.
    if (xfer) begin
      pend_d     = 1'b1;
      pend_val_d = clamped;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      psc_q      <= '0;
      cnt_q      <= '0;
      active_q   <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      wave_q     <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      psc_q      <= psc_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      wave_q     <= wave_d;
      pulse_q    <= pulse_d;
    end
  end

  assign period_ready = !pend_q;
  assign wave_out     = wave_q;
  assign pulse_out    = pulse_q;
  assign running      = (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_freq_generator.sv
`default_nettype none
// ============================================================================
// tb_freq_generator : two generator instances (PSC_DIV 1 and 4) checked
// against a clk-domain timing model through per-instance expectation queues.
// Revision 1.0
// ============================================================================
module tb_freq_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [9:0] period_in;
  logic       va, vb;
  logic       ready_a, wave_a, pulse_a, run_a;
  logic       ready_b, wave_b, pulse_b, run_b;

  always #5 clk = ~clk;

  freq_generator #(.CNTR_SIZE(10), .PSC_DIV(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .period_in(period_in), .period_valid(va),
    .period_ready(ready_a), .wave_out(wave_a), .pulse_out(pulse_a), .running(run_a)
  );

  freq_generator #(.CNTR_SIZE(5), .PSC_DIV(4)) u_b (
    .clk(clk), .rst(rst), .en(en), .period_in(period_in[4:0]), .period_valid(vb),
    .period_ready(ready_b), .wave_out(wave_b), .pulse_out(pulse_b), .running(run_b)
  );

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  // Expected {running, ready, wave, pulse} after each rising edge.
  logic [3:0] q_a[$];
  logic [3:0] q_b[$];

  // Model: t counts clk cycles since the start of the current period.
  int m_run[2], m_p[2], m_pend[2], m_pv[2], m_t[2];
  int div[2]  = '{1, 4};
  int mask[2] = '{1023, 31};

  task automatic check(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [3:0] model_step(int k, bit rst_i, bit en_i, bit valid, int pin);
    bit xfer, wave, pulse;
    int oldp, req;
    wave = 1'b0;
    pulse = 1'b0;
    if (!rst_i) begin
      m_run[k] = 0; m_p[k] = 0; m_pend[k] = 0; m_pv[k] = 0; m_t[k] = 0;
      return 4'b0100;
    end
    xfer = valid && (m_pend[k] == 0);
    if (m_run[k] != 0 && en_i) begin
      wave  = m_t[k] < (m_p[k] / 2) * div[k];
      pulse = (m_t[k] == 0);
    end
    if (m_run[k] == 0) begin
      oldp = m_p[k];
      m_t[k] = 0;
      if (m_pend[k] != 0) begin m_p[k] = m_pv[k]; m_pend[k] = 0; end
      m_run[k] = (en_i && oldp != 0) ? 1 : 0;
    end else if (!en_i) begin
      m_run[k] = 0;
      m_t[k] = 0;
    end else if (m_t[k] == m_p[k] * div[k] - 1) begin
      m_t[k] = 0;
      if (m_pend[k] != 0) begin m_p[k] = m_pv[k]; m_pend[k] = 0; end
    end else begin
      m_t[k]++;
    end
    if (xfer) begin
      req = pin & mask[k];
      m_pend[k] = 1;
      m_pv[k] = (req < 2) ? 2 : req;
    end
    return {m_run[k] != 0, m_pend[k] == 0, wave, pulse};
  endfunction

  task automatic cycle(bit r, bit e, bit a, bit b, int pin);
    @(negedge clk);
    rst = r; en = e; va = a; vb = b; period_in = pin[9:0];
    q_a.push_back(model_step(0, r, e, a, pin));
    q_b.push_back(model_step(1, r, e, b, pin));
    if (!r) begin
      #1;
      check("rst_wave_a", wave_a, 0);   check("rst_pulse_a", pulse_a, 0);
      check("rst_run_a", run_a, 0);     check("rst_ready_a", ready_a, 1);
      check("rst_wave_b", wave_b, 0);   check("rst_pulse_b", pulse_b, 0);
      check("rst_run_b", run_b, 0);     check("rst_ready_b", ready_b, 1);
    end
  endtask

  initial begin : monitor
    logic [3:0] e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("run_a", run_a, e[3]);   check("ready_a", ready_a, e[2]);
        check("wave_a", wave_a, e[1]); check("pulse_a", pulse_a, e[0]);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("run_b", run_b, e[3]);   check("ready_b", ready_b, e[2]);
        check("wave_b", wave_b, e[1]); check("pulse_b", pulse_b, e[0]);
      end
    end
  end

  initial begin : stimulus
    int plist[6] = '{8, 0, 1, 5, 3, 10};
    bit e_r;
    rst = 1'b0; en = 1'b0; va = 1'b0; vb = 1'b0; period_in = '0;
    repeat (3) cycle(0, 0, 0, 0, 0);

    // Load each period in IDLE, run, then change period mid-run.
    foreach (plist[i]) begin
      repeat (3) cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 1, 1, plist[i]);
      repeat (2) cycle(1, 0, 0, 0, 0);
      repeat (50) cycle(1, 1, 0, 0, 0);
      repeat (20) cycle(1, 1, 1, 1, 12);
      repeat (60) cycle(1, 1, 0, 0, 0);
      repeat (7) cycle(1, 1, 1, 1, 6 + i);
    end

    // Randomized enables, handshakes and period words.
    e_r = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      int pin;
      if ($urandom_range(0, 49) == 0) e_r = !e_r;
      pin = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 20));
      cycle(1, e_r, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, pin);
    end

    // Asynchronous reset while running, then recovery.
    cycle(1, 0, 1, 1, 10);
    repeat (2) cycle(1, 0, 0, 0, 0);
    repeat (17) cycle(1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    repeat (3) cycle(1, 0, 0, 0, 0);
    repeat (3) cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 1, 1, 10);
    repeat (2) cycle(1, 0, 0, 0, 0);
    repeat (60) cycle(1, 1, 0, 0, 0);

    @(negedge clk);
    done = 1'b1;
    @(posedge clk);
    #2;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d required=0", q_a.size() + q_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
